// File: rtl/fsm_moore_run_det.sv
// Moore run detector: o_output is high while the last RUN_LEN accepted symbols form
// an equal run (mode 0) or a +1-with-wrap run (mode 1); also reports run length and hit count.
module fsm_moore_run_det #(
  parameter int DW      = 2,
  parameter int RUN_LEN = 3,
  parameter int HIT_W   = 8,
  localparam int CNT_W  = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [DW-1:0]    i_input,
  input  logic             i_mode,
  input  logic             i_clear,
  output logic             o_output,
  output logic [CNT_W-1:0] o_run_len,
  output logic [HIT_W-1:0] o_hit_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OK   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   run_q, run_d;
  logic [DW-1:0]      last_q, last_d;
  logic [HIT_W-1:0]   hit_q, hit_d;
  logic [DW-1:0]      last_inc;
  logic               match;

  // Increment mode compares against last+1 truncated to DW bits, so the top symbol wraps to 0.
  assign last_inc = last_q + DW'(1);
  assign match    = i_mode ? (i_input == last_inc) : (i_input == last_q);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    last_d  = last_q;
    hit_d   = hit_q;
    if (i_clear) begin
      state_d = IDLE;
      run_d   = '0;
      last_d  = '0;
    end else if (i_valid) begin
      last_d = i_input;
      case (state_q)
        IDLE: begin
          state_d = RUN;
          run_d   = RUN_ONE;
        end
        RUN: begin
          if (match) begin
            run_d = run_q + RUN_ONE;
            if (run_q + RUN_ONE == RUN_MAX) begin
              state_d = OK;
              if (hit_q != '1) hit_d = hit_q + HIT_W'(1);
            end
          end else begin
            run_d = RUN_ONE;
          end
        end
        OK: begin
          // A matching symbol keeps the run saturated at RUN_LEN without a new hit.
          if (!match) begin
            state_d = RUN;
            run_d   = RUN_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= '0;
      last_q  <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      last_q  <= last_d;
      hit_q   <= hit_d;
    end
  end

  assign o_output  = (state_q == OK);
  assign o_run_len = run_q;
  assign o_hit_cnt = hit_q;

endmodule
